// File: rtl/fp_mul_pkg.sv
// Shared widths and FSM encoding for the iterative carry-save mantissa multiplier.
package fp_mul_pkg;

    localparam int MANT_W        = 24;
    localparam int PROD_W        = 48;
    localparam int BITS_PER_ITER = 4;
    localparam int N_ITER        = 6;
    localparam int ITER_W        = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save adder over a full product-width word; purely combinational, no backpressure.
// The carry vector comes out pre-shifted by one with bit W dropped, so sum + carry is exact mod 2^W.
module csa_3to2 #(
    parameter int W = 48
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_mult_iter.sv
// 24x24 radix-16 iterative multiplier leaving a 48-bit carry-save pair; valid pulses 6 cycles after start.
// One multiply in flight; start is ignored (not queued) while busy is high.
module csa_mult_iter
    import fp_mul_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    output logic              busy,
    output logic              valid,
    output logic [PROD_W-1:0] s9_final,
    output logic [PROD_W-1:0] c9_final
);

    state_t              state, next_state;
    logic [PROD_W-1:0]   a_reg, s_acc, c_acc;
    logic [MANT_W-1:0]   b_reg;
    logic [ITER_W-1:0]   iter;
    logic                last_iter;

    logic [PROD_W-1:0]   pp [BITS_PER_ITER];
    logic [PROD_W-1:0]   s1, c1, s2, c2, s3, c3, s4, c4;

    assign busy      = (state == RUN);
    assign last_iter = (iter == ITER_W'(N_ITER - 1));

    always_comb begin
        for (int i = 0; i < BITS_PER_ITER; i++) begin
            pp[i] = b_reg[i] ? (a_reg << i) : '0;
        end
    end

    // Six operands (four partial products plus the running pair) folded down to two.
    csa_3to2 #(.W(PROD_W)) u_csa_l1 (.a(pp[0]), .b(pp[1]),  .c(pp[2]), .sum(s1), .carry(c1));
    csa_3to2 #(.W(PROD_W)) u_csa_l2 (.a(pp[3]), .b(s_acc),  .c(c_acc), .sum(s2), .carry(c2));
    csa_3to2 #(.W(PROD_W)) u_csa_l3 (.a(s1),    .b(c1),     .c(s2),    .sum(s3), .carry(c3));
    csa_3to2 #(.W(PROD_W)) u_csa_l4 (.a(s3),    .b(c3),     .c(c2),    .sum(s4), .carry(c4));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = RUN;
            RUN:     if (last_iter) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_acc    <= '0;
            c_acc    <= '0;
            iter     <= '0;
            valid    <= 1'b0;
            s9_final <= '0;
            c9_final <= '0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_reg <= {{(PROD_W - MANT_W){1'b0}}, mant_a};
                    b_reg <= mant_b;
                    s_acc <= '0;
                    c_acc <= '0;
                    iter  <= '0;
                end
            end else begin
                a_reg <= a_reg << BITS_PER_ITER;
                b_reg <= b_reg >> BITS_PER_ITER;
                s_acc <= s4;
                c_acc <= c4;
                iter  <= iter + ITER_W'(1);
                if (last_iter) begin
                    s9_final <= s4;
                    c9_final <= c4;
                    valid    <= 1'b1;
                end
            end
        end
    end

endmodule
